order_egress_fifo: RTL
======================

# order_egress_fifo

Downstream of the reverse parser: captures each completed outbound order (seven 32-bit words plus valid strobe) into a small record FIFO. Streams records to the exchange-side transmit path one word per beat over a valid/ready handshake, marking the final word with last. The reverse parser has no backpressure input, so a record arriving while the FIFO is full is dropped and counted.

## Interface
- REG_WIDTH, 32, width of each order word
- DEPTH, 4, record slots; power of two, ≥2
- CNT_WIDTH, 16, width of drop counter
- i_clk  in  1  single clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_reg_1 … i_reg_7  in  REG_WIDTH each  order record words 0..6 from reverse parser
- i_valid  in  1  one-cycle strobe: i_reg_1..7 hold a complete record
- o_tdata  out  REG_WIDTH  current outbound word
- o_tvalid  out  1  o_tdata valid
- i_tready  in  1  consumer accepts word when o_tvalid & i_tready
- o_tlast  out  1  high on final word of a record
- o_count  out  $clog2(DEPTH)+1  records stored, including one in transmission
- o_full  out  1  o_count == DEPTH
- o_drop_cnt  out  CNT_WIDTH  records dropped since reset, saturating

## Operation
- Storage: DEPTH × REC_WORDS × REG_WIDTH registers; wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap); count.
- Push: on i_valid, record written at wr_ptr and wr_ptr++ if !o_full, or if o_full and the final-word handshake (pop) occurs in the same cycle.
- Otherwise, i_valid while full: record discarded, o_drop_cnt++ (holds at all-ones).
- Pop: handshake on word REC_WORDS-1 frees slot, rd_ptr++.
- Simultaneous push and pop: count unchanged.
- FSM states IDLE, STREAM.
  - IDLE: o_tvalid=0, word_idx=0. Go to STREAM when count≠0.
  - STREAM: o_tvalid=1, o_tdata=mem[rd_ptr][word_idx], o_tlast=(word_idx==REC_WORDS-1).
  - On handshake with !o_tlast: word_idx++.
  - On handshake with o_tlast: word_idx=0; stay in STREAM if count after pop ≠0, else go to IDLE.
- o_tdata/o_tlast stay stable while o_tvalid & !i_tready (AXI-stream rule). A push never alters the slot being read.
- Word order: i_reg_1 first … i_reg_7 last.
- Reset (any time, including mid-record): state IDLE, pointers/count/word_idx/o_drop_cnt = 0, o_tvalid=0, o_tlast=0, o_tdata=0, o_full=0. Partially sent record is lost; storage contents need not be cleared.

## Timing
- Push at edge N: o_count updates after edge N; o_tvalid high from cycle N+1 (IDLE→STREAM at edge N+1 output-registered) — first word visible one cycle after the push edge.
- Throughput: one word per cycle with i_tready held high. Back-to-back records have no bubble (STREAM→STREAM).
- o_full, o_count, o_drop_cnt are registered and reflect state after the latest edge.

## Configuration
- ORDER_EGRESS_TIMESTAMP_EN defined: REC_WORDS=8. A free-running REG_WIDTH cycle counter (reset 0, wraps) is captured at push and sent as word 7 after i_reg_7; o_tlast on word 7.
- Not defined: REC_WORDS=7, no counter logic.

## Structure
- Package hft_egress_pkg holds:
  - REC_WORDS (macro-dependent)
  - state enum egress_state_t {IDLE, STREAM}
  - record typedef egress_rec_t (array of REC_WORDS words)
- One sub-module, egress_record_ram: DEPTH × egress_rec_t register array with a write port (whole record) and a combinational word-indexed read port.
- Pointers, counters and FSM stay in order_egress_fifo.

## Test plan
- Single record, words 0x11..0x17, i_tready=1 → o_tvalid from cycle after push; 7 beats 0x11..0x17; o_tlast on 0x17 only; o_count 1→0; FSM returns to IDLE.
- Stall: i_tready low for 3 cycles on word 2 → o_tdata holds word 2 throughout; stream then resumes in order.
- Fill: 5 pushes, DEPTH=4, i_tready=0 → o_full=1 after 4th; 5th dropped; o_drop_cnt=1; draining yields records 1–4 only.
- Full + push on final-word handshake → push accepted, o_count stays 4, o_drop_cnt unchanged.
- Reset asserted mid-record (after word 3) → all outputs 0 immediately; after release, a new push streams from word 0.
- With ORDER_EGRESS_TIMESTAMP_EN: push at counter value 0x2A → 8 beats; word 7 = 0x2A with o_tlast.

Source files
------------

// File: rtl/hft_egress_pkg.sv
// Shared record geometry and FSM type for the order egress FIFO.
// ORDER_EGRESS_TIMESTAMP_EN adds an eighth record word carrying the push-time cycle stamp.
package hft_egress_pkg;

`ifdef ORDER_EGRESS_TIMESTAMP_EN
  localparam int REC_WORDS = 8;
`else
  localparam int REC_WORDS = 7;
`endif

  localparam int IDX_WIDTH     = $clog2(REC_WORDS);
  localparam int DEF_REG_WIDTH = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } egress_state_t;

  // Record at the default word width; word 0 is transmitted first.
  typedef logic [REC_WORDS-1:0][DEF_REG_WIDTH-1:0] egress_rec_t;

endpackage

// File: rtl/egress_record_ram.sv
// Register array of DEPTH order records: whole-record write port and a
// combinational word-indexed read port. Contents are not reset.
module egress_record_ram
  import hft_egress_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REG_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [$clog2(DEPTH)-1:0]             waddr,
  input  logic [REC_WORDS-1:0][REG_WIDTH-1:0]  wdata,
  input  logic [$clog2(DEPTH)-1:0]             raddr,
  input  logic [IDX_WIDTH-1:0]                 ridx,
  output logic [REG_WIDTH-1:0]                 rdata
);

  logic [REC_WORDS-1:0][REG_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr][ridx];

endmodule

// File: rtl/order_egress_fifo.sv
// Record FIFO between the reverse parser and the exchange transmit stream.
// Build option ORDER_EGRESS_TIMESTAMP_EN appends a free-running cycle stamp as word 7.
module order_egress_fifo
  import hft_egress_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [REG_WIDTH-1:0]     i_reg_1,
  input  logic [REG_WIDTH-1:0]     i_reg_2,
  input  logic [REG_WIDTH-1:0]     i_reg_3,
  input  logic [REG_WIDTH-1:0]     i_reg_4,
  input  logic [REG_WIDTH-1:0]     i_reg_5,
  input  logic [REG_WIDTH-1:0]     i_reg_6,
  input  logic [REG_WIDTH-1:0]     i_reg_7,
  input  logic                     i_valid,
  output logic [REG_WIDTH-1:0]     o_tdata,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic                     o_tlast,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic [CNT_WIDTH-1:0]     o_drop_cnt,
  output egress_state_t            o_state
);

  // Handshake: a word moves when o_tvalid & i_tready at a rising edge; while
  // o_tvalid is high and i_tready low, o_tdata/o_tlast are held unchanged.
  localparam int                   AW       = $clog2(DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REC_WORDS - 1);
  localparam logic [AW:0]          FULL_CNT = (AW + 1)'(DEPTH);

  egress_state_t                       state, state_nxt;
  logic [AW-1:0]                       wr_ptr, rd_ptr;
  logic [AW:0]                         count, count_nxt;
  logic [IDX_WIDTH-1:0]                word_idx;
  logic [CNT_WIDTH-1:0]                drop_cnt;
  logic [REC_WORDS-1:0][REG_WIDTH-1:0] wr_rec;
  logic [REG_WIDTH-1:0]                rd_word;
  logic                                full, hs, pop, push, drop;

  assign full = (count == FULL_CNT);
  assign hs   = (state == STREAM) && i_tready;
  assign pop  = hs && (word_idx == LAST_IDX);
  // A full FIFO still accepts when the head slot is freed on this same edge.
  assign push = i_valid && (!full || pop);
  assign drop = i_valid && !push;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

`ifdef ORDER_EGRESS_TIMESTAMP_EN
  logic [REG_WIDTH-1:0] ts_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  always_comb begin
    wr_rec    = '0;
    wr_rec[0] = i_reg_1;
    wr_rec[1] = i_reg_2;
    wr_rec[2] = i_reg_3;
    wr_rec[3] = i_reg_4;
    wr_rec[4] = i_reg_5;
    wr_rec[5] = i_reg_6;
    wr_rec[6] = i_reg_7;
`ifdef ORDER_EGRESS_TIMESTAMP_EN
    wr_rec[7] = ts_cnt;
`endif
  end

  egress_record_ram #(
    .DEPTH     (DEPTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .ridx  (word_idx),
    .rdata (rd_word)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // FSM state register, including the word index within the head record.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (pop)     word_idx <= '0;
      else if (hs) word_idx <= word_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = STREAM;
      STREAM:  if (pop && (count_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    if (state == STREAM) begin
      o_tvalid = 1'b1;
      o_tlast  = (word_idx == LAST_IDX);
      o_tdata  = rd_word;
    end
  end

  assign o_count    = count;
  assign o_full     = full;
  assign o_drop_cnt = drop_cnt;
  assign o_state    = state;

endmodule
